// File: rtl/param_alu.sv
// Multi-cycle parameterised ALU: single-cycle add/sub/logic/shift, iterative
// shift-add multiply, registered result and flags held until the next operation.
module param_alu #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           opcode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 zero,
   output logic                 carry,
   output logic                 illegal
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   state_t            r_state;
   logic              r_busy;
   logic              r_done;
   logic [W2-1:0]     r_result;
   logic              r_zero;
   logic              r_carry;
   logic              r_illegal;
   logic [W2-1:0]     r_mcand;
   logic [WIDTH-1:0]  r_b;
   logic [W2-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_diff;
   logic [W2-1:0]     w_alu_res;
   logic              w_alu_carry;
   logic              w_alu_ill;
   logic [W2-1:0]     w_mul_acc;

   // Single-cycle ops finish on the accepting edge, so they are evaluated from
   // the live inputs; the captured copies only feed the multiplier.
   always_comb begin
      w_sum       = {1'b0, a} + {1'b0, b};
      w_diff      = {1'b0, a} - {1'b0, b};
      w_alu_res   = '0;
      w_alu_carry = 1'b0;
      w_alu_ill   = 1'b0;
      case (opcode)
         3'b000: begin
            w_alu_res   = {{(WIDTH-1){1'b0}}, w_sum};
            w_alu_carry = w_sum[WIDTH];
         end
         3'b001: begin
            w_alu_res   = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            w_alu_carry = ~w_diff[WIDTH];
         end
         3'b011: w_alu_res = {{WIDTH{1'b0}}, a & b};
         3'b100: w_alu_res = {{WIDTH{1'b0}}, a | b};
         3'b101: w_alu_res = {{WIDTH{1'b0}}, a ^ b};
         3'b110: w_alu_res = W2'(a) << b[CW-1:0];
         3'b111: w_alu_ill = 1'b1;
         default: w_alu_res = '0;
      endcase
   end

   assign w_mul_acc = r_acc + (r_b[r_cnt] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_carry   <= 1'b0;
         r_illegal <= 1'b0;
         r_mcand   <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand <= W2'(a);
                  r_b     <= b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (opcode == 3'b010) begin
                     r_state <= MUL;
                  end else begin
                     r_state   <= DONE;
                     r_done    <= 1'b1;
                     r_result  <= w_alu_res;
                     r_zero    <= (w_alu_res == '0);
                     r_carry   <= w_alu_carry;
                     r_illegal <= w_alu_ill;
                  end
               end
            end
            MUL: begin
               r_acc   <= w_mul_acc;
               r_mcand <= {r_mcand[W2-2:0], 1'b0};
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state   <= DONE;
                  r_done    <= 1'b1;
                  r_result  <= w_mul_acc;
                  r_zero    <= (w_mul_acc == '0);
                  r_carry   <= 1'b0;
                  r_illegal <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;
   assign zero    = r_zero;
   assign carry   = r_carry;
   assign illegal = r_illegal;

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu at WIDTH 4/8/16/32: drivers push expected
// responses from an arithmetic reference model, one monitor pops and compares.
module tb_param_alu;

   localparam int WS[4] = '{4, 8, 16, 32};

   typedef struct {
      int          cyc;
      logic [63:0] res;
      logic        z;
      logic        c;
      logic        il;
   } exp_t;

   localparam exp_t RST = '{cyc: 0, res: 64'd0, z: 1'b1, c: 1'b0, il: 1'b0};

   logic        clk;
   logic        rst_s   [4];
   logic        st_s    [4];
   logic [2:0]  op_s    [4];
   logic [31:0] a_s     [4];
   logic [31:0] b_s     [4];
   logic        busy_s  [4];
   logic        done_s  [4];
   logic        zero_s  [4];
   logic        carry_s [4];
   logic        ill_s   [4];
   logic [63:0] res_s   [4];
   logic [7:0]  res4;
   logic [15:0] res8;
   logic [31:0] res16;
   logic [63:0] res32;

   exp_t sbq [4][$];
   exp_t hold [4];
   int   nfree [4];
   int   blo [4];
   int   bhi [4];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   mon_en = 0;
   bit   end_req = 0;
   bit   mon_fin = 0;

   param_alu #(.WIDTH(4)) u_w4 (
      .clk(clk), .reset(rst_s[0]), .start(st_s[0]), .opcode(op_s[0]),
      .a(a_s[0][3:0]), .b(b_s[0][3:0]), .busy(busy_s[0]), .done(done_s[0]),
      .result(res4), .zero(zero_s[0]), .carry(carry_s[0]), .illegal(ill_s[0]));
   param_alu #(.WIDTH(8)) u_w8 (
      .clk(clk), .reset(rst_s[1]), .start(st_s[1]), .opcode(op_s[1]),
      .a(a_s[1][7:0]), .b(b_s[1][7:0]), .busy(busy_s[1]), .done(done_s[1]),
      .result(res8), .zero(zero_s[1]), .carry(carry_s[1]), .illegal(ill_s[1]));
   param_alu #(.WIDTH(16)) u_w16 (
      .clk(clk), .reset(rst_s[2]), .start(st_s[2]), .opcode(op_s[2]),
      .a(a_s[2][15:0]), .b(b_s[2][15:0]), .busy(busy_s[2]), .done(done_s[2]),
      .result(res16), .zero(zero_s[2]), .carry(carry_s[2]), .illegal(ill_s[2]));
   param_alu #(.WIDTH(32)) u_w32 (
      .clk(clk), .reset(rst_s[3]), .start(st_s[3]), .opcode(op_s[3]),
      .a(a_s[3]), .b(b_s[3]), .busy(busy_s[3]), .done(done_s[3]),
      .result(res32), .zero(zero_s[3]), .carry(carry_s[3]), .illegal(ill_s[3]));

   assign res_s[0] = {56'd0, res4};
   assign res_s[1] = {48'd0, res8};
   assign res_s[2] = {32'd0, res16};
   assign res_s[3] = res32;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: plain arithmetic on the operand values.
   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  input int acc_cyc);
      exp_t e;
      longint unsigned ua, ub, r, m2;
      ua = longint'(av);
      ub = longint'(bv);
      m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      e.c  = 1'b0;
      e.il = 1'b0;
      case (op)
         3'd0: begin r = ua + ub; e.c = ((r >> w) != 0); end
         3'd1: begin r = (ua - ub) & m2; e.c = (ua >= ub); end
         3'd2: r = ua * ub;
         3'd3: r = ua & ub;
         3'd4: r = ua | ub;
         3'd5: r = ua ^ ub;
         3'd6: r = ua << (ub % longint'(w));
         default: begin r = 0; e.il = 1'b1; end
      endcase
      e.res = r;
      e.z   = (r == 0);
      e.cyc = acc_cyc + ((op == 3'd2) ? w : 0);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int k, input logic [2:0] op,
                        input logic [31:0] av, input logic [31:0] bv);
      int          w;
      int          p;
      logic [31:0] msk;
      exp_t        e;
      w   = WS[k];
      msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      op_s[k] = op;
      a_s[k]  = av & msk;
      b_s[k]  = bv & msk;
      st_s[k] = 1'b1;
      p = cyc + 1;
      if (p >= nfree[k]) begin
         e = model(w, op, av & msk, bv & msk, p);
         sbq[k].push_back(e);
         blo[k]   = p;
         bhi[k]   = e.cyc;
         nfree[k] = e.cyc + 2;
      end
      step();
      st_s[k] = 1'b0;
      op_s[k] = 3'($urandom);
      a_s[k]  = $urandom & msk;
      b_s[k]  = $urandom & msk;
   endtask

   task automatic do_reset(input int k);
      rst_s[k] = 1'b1;
      st_s[k]  = 1'b1;
      op_s[k]  = 3'd0;
      step();
      sbq[k].delete();
      hold[k]  = RST;
      blo[k]   = 1;
      bhi[k]   = 0;
      nfree[k] = cyc + 1;
      rst_s[k] = 1'b0;
      st_s[k]  = 1'b0;
   endtask

   task automatic rand_seq(input int k);
      repeat (120) begin
         repeat ($urandom_range(0, 3)) step();
         if ($urandom_range(0, 39) == 0) do_reset(k);
         else issue(k, 3'($urandom), $urandom, $urandom);
      end
   endtask

   task automatic chk(input string nm, input int k,
                      input longint unsigned act, input longint unsigned exv);
      n_chk++;
      if (act != exv) begin
         n_fail++;
         $display("FAIL %s W=%0d cycle %0d: got 0x%0h expected 0x%0h",
                  nm, WS[k], cyc, act, exv);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
               if (done_s[k]) begin
                  if (sbq[k].size() == 0) begin
                     chk("done_unexpected", k, 1, 0);
                  end else begin
                     e = sbq[k].pop_front();
                     chk("done_cycle", k, cyc, e.cyc);
                     hold[k] = e;
                  end
               end else if (sbq[k].size() != 0 && cyc > sbq[k][0].cyc) begin
                  chk("done_missing", k, cyc, sbq[k][0].cyc);
                  void'(sbq[k].pop_front());
               end
               chk("busy", k, busy_s[k], (cyc >= blo[k] && cyc <= bhi[k]) ? 1 : 0);
               chk("result", k, res_s[k], hold[k].res);
               chk("zero", k, zero_s[k], hold[k].z);
               chk("carry", k, carry_s[k], hold[k].c);
               chk("illegal", k, ill_s[k], hold[k].il);
            end
         end
         if (end_req && !mon_fin) begin
            for (int k = 0; k < 4; k++) chk("queue_drained", k, sbq[k].size(), 0);
            mon_fin = 1;
         end
      end
   end

   initial begin
      for (int k = 0; k < 4; k++) begin
         rst_s[k] = 1'b1;
         st_s[k]  = 1'b0;
         op_s[k]  = 3'd0;
         a_s[k]   = '0;
         b_s[k]   = '0;
         blo[k]   = 1;
         bhi[k]   = 0;
      end
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         rst_s[k] = 1'b0;
         hold[k]  = RST;
         nfree[k] = cyc + 1;
      end
      mon_en = 1;

      issue(2, 3'd0, 32'hFFFF, 32'h0001);
      step();
      issue(2, 3'd1, 32'h0003, 32'h0005);
      step();
      issue(2, 3'd1, 32'h0005, 32'h0005);
      step();
      issue(2, 3'd2, 32'hFFFF, 32'hFFFF);
      repeat (16) issue(2, 3'($urandom), $urandom, $urandom);
      step();
      step();
      issue(1, 3'd6, 32'h81, 32'h07);
      step();
      issue(1, 3'd7, 32'h12, 32'h34);
      step();
      issue(2, 3'd2, 32'h1234, 32'h0010);
      repeat (7) step();
      do_reset(2);
      issue(2, 3'd0, 32'd2, 32'd3);
      step();
      issue(1, 3'd3, 32'hF0, 32'h3C);
      issue(1, 3'd4, 32'hF0, 32'h3C);
      step();
      issue(1, 3'd5, 32'hF0, 32'h3C);
      step();

      fork
         rand_seq(0);
         rand_seq(2);
         rand_seq(3);
      join

      repeat (40) step();
      end_req = 1;
      repeat (3) step();
      if (!mon_fin) begin
         $display("FAIL monitor_drain: monitor did not complete");
         $fatal(1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand width; legal range 4..32, even values only.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  operation request; sampled only while busy=0.
REQ-005 opcode  input  3  operation select, latched with start.
REQ-006 a  input  WIDTH  operand A, unsigned, latched with start.
REQ-007 b  input  WIDTH  operand B, unsigned, latched with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  2*WIDTH  operation result, held until next accepted start.
REQ-011 zero  output  1  result == 0, updated with done.
REQ-012 carry  output  1  carry-out (add) / no-borrow (sub), else 0; updated with done.
REQ-013 illegal  output  1  opcode 111 was executed; updated with done.

Function
REQ-014 Start accepted at a rising edge where start=1, busy=0, reset=0; opcode, a, b captured into internal registers at that edge.
REQ-015 start while busy=1 ignored; in-flight operation and captured operands unaffected.
REQ-016 Operations on captured operands: 000 add, 001 sub, 010 unsigned multiply, 011 AND, 100 OR, 101 XOR, 110 logical shift left, 111 illegal.
REQ-017 Add: result = zero-extended WIDTH+1-bit sum {cout, a+b}; carry = cout.
REQ-018 Sub: a-b as WIDTH+1-bit two's complement, sign-extended to 2*WIDTH; carry = 1 iff a >= b.
REQ-019 Logic ops: WIDTH-bit result zero-extended to 2*WIDTH; carry = 0.
REQ-020 Shift: result = zero-extended a shifted left by b[$clog2(WIDTH)-1:0], computed in 2*WIDTH bits (no truncation); carry = 0.
REQ-021 Illegal: result = 0, illegal = 1, carry = 0; otherwise illegal = 0.
REQ-022 FSM states IDLE, MUL, DONE; IDLE -> MUL on accepted multiply, IDLE -> DONE on any other accepted opcode, MUL -> DONE after WIDTH iterations, DONE -> IDLE unconditionally.
REQ-023 Multiply: iterative shift-add, one multiplier bit per cycle, WIDTH-cycle iteration counter; full 2*WIDTH-bit unsigned product, no truncation; carry = 0.
REQ-024 busy = 1 in MUL and DONE, 0 in IDLE; busy rises the cycle after acceptance.
REQ-025 done = 1 only in DONE, for exactly one cycle per accepted start.
REQ-026 Latency: non-multiply done visible 1 cycle after accepting edge; multiply done visible WIDTH+1 cycles after it (17 at WIDTH=16).
REQ-027 result, zero, carry, illegal update only on entry to DONE; held stable all other cycles, including during a following multiply.
REQ-028 Next start accepted earliest at the edge where the FSM returns to IDLE (the cycle after done); back-to-back throughput 1 op per 2 cycles for non-multiply ops.
REQ-029 Input changes to a, b, opcode after acceptance have no effect on the current operation.

Reset
REQ-030 reset=1 at a rising edge forces IDLE, busy=0, done=0, result=0, zero=1, carry=0, illegal=0, iteration counter and operand registers = 0.
REQ-031 reset has priority over start and over any in-flight operation; aborted operation produces no done pulse, ever.
REQ-032 start asserted in the same cycle as reset is ignored; first accept possible at the first edge with reset=0.

Verification
REQ-033 WIDTH=16, add a=0xFFFF b=0x0001 -> done after 1 cycle, result=0x00010000, carry=1, zero=0.
REQ-034 WIDTH=16, sub a=0x0003 b=0x0005 -> result=0xFFFFFFFE, carry=0; sub a=5 b=5 -> result=0, zero=1, carry=1.
REQ-035 WIDTH=16, mul a=0xFFFF b=0xFFFF -> busy for 17 cycles, done at cycle 17, result=0xFFFE0001; start pulses mid-operation ignored.
REQ-036 WIDTH=8, shift a=0x81 b=0x07 -> result=0x4080; opcode 111 -> result=0, illegal=1, done after 1 cycle.
REQ-037 WIDTH=16, mul a=0x1234 b=0x0010, reset asserted at cycle 8 -> no done pulse, all outputs at reset values next cycle; fresh add 2+3 afterwards -> result=5.
REQ-038 Random regression WIDTH in {4,16,32}, all opcodes, random start timing -> every result/flag matches reference model; exactly one done per accepted start.
